enoc_switch_allocator: RTL

Per-router switch allocator, directly downstream of the route calculators. Collects the one-hot [c,n,e,s,w] output-port requests from all N input ports' route calculators. Resolves output-port contention with one round-robin arbiter per output. Returns grants that drive the crossbar select and dequeue the winning input buffers.

---
 rtl/enoc_switch_allocator.sv | 65 ++++++
 1 files changed

// File: rtl/enoc_switch_allocator.sv
// Per-router switch allocator: one rotating-priority arbiter per output port,
// zero-latency grants, pointer advances past each winner on the next edge.
module enoc_switch_allocator #(
   parameter int N = 5
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [0:N-1][0:N-1]    i_output_req,
   input  logic [0:N-1]           i_en,
   output logic [0:N-1][0:N-1]    o_output_grant,
   output logic [0:N-1]           o_input_grant,
   output logic [0:N-1]           o_output_val
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr [N];
   logic [PW-1:0] win [N];

   // Scan starts at ptr[j] and wraps; grants are forced low while in reset.
   always_comb begin
      logic [PW:0]   sum;
      logic [PW-1:0] idx;
      logic          found;
      o_output_grant = '0;
      for (int j = 0; j < N; j++) begin
         win[j] = '0;
         found  = 1'b0;
         for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr[j]} + (PW+1)'(k);
            if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
            idx = sum[PW-1:0];
            if (!found && reset_n && i_en[j] && i_output_req[idx][j]) begin
               o_output_grant[j][idx] = 1'b1;
               win[j]                 = idx;
               found                  = 1'b1;
            end
         end
      end
   end

   always_comb begin
      o_input_grant = '0;
      o_output_val  = '0;
      for (int j = 0; j < N; j++) begin
         o_output_val[j] = |o_output_grant[j];
         for (int i = 0; i < N; i++) begin
            o_input_grant[i] = o_input_grant[i] | o_output_grant[j][i];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int j = 0; j < N; j++) ptr[j] <= '0;
      end else begin
         for (int j = 0; j < N; j++) begin
            if (o_output_val[j]) begin
               ptr[j] <= (win[j] == PW'(N-1)) ? '0 : win[j] + PW'(1);
            end
         end
      end
   end

endmodule
